// File: rtl/ar429_pkg.sv
// Shared ARINC-429 word constants, FSM states and word packing.
// Used by both the transmit and receive sides.
package ar429_pkg;

    localparam int WORD_BITS = 32;
    localparam int ADR_W     = 8;
    localparam int DAT_W     = 23;

    typedef enum logic [1:0] {
        IDLE,
        BIT_HI,
        BIT_LO,
        GAP
    } ar_state_e;

    // Index k of the result is the k-th bit on the line.
    function automatic logic [WORD_BITS-1:0] ar_pack(
        input logic [ADR_W-1:0] adr,
        input logic [DAT_W-1:0] dat
    );
        logic [WORD_BITS-1:0] w;
        w = '0;
        for (int k = 0; k < ADR_W; k++) begin
            w[k] = adr[ADR_W-1-k];
        end
        for (int j = 0; j < DAT_W; j++) begin
            w[ADR_W+j] = dat[j];
        end
        w[WORD_BITS-1] = ~^{adr, dat};
        return w;
    endfunction

endpackage

// File: rtl/ar_txd_fifo.sv
// Small word FIFO ahead of the serialiser (AR_TXD_FIFO_EN builds only).
// A push on full succeeds when a pop happens in the same cycle.
module ar_txd_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ar_txd_word.sv
// ARINC-429 return-to-zero word transmitter.
// Define AR_TXD_FIFO_EN for a 4-entry word FIFO in front of the serialiser.
module ar_txd_word
    import ar429_pkg::*;
#(
    parameter int CLK_PER_BIT = 500,
    parameter int GAP_BITS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DAT_W-1:0]  dat,
    input  logic              st,
    output logic              rdy,
    output logic              TXD1,
    output logic              TXD0,
    output logic              done
);

    localparam int HALF    = CLK_PER_BIT / 2;
    localparam int HW      = $clog2(CLK_PER_BIT);
    localparam int GAP_CYC = GAP_BITS * CLK_PER_BIT;
    localparam int GW      = $clog2(GAP_CYC);

    ar_state_e            state_q, state_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [4:0]           bit_q, bit_d;
    logic [HW-1:0]        half_q, half_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 txd1_q, txd0_q, done_q;
    logic                 txd1_d, txd0_d, done_d;
    logic                 alive_q;
    logic                 load;
    logic [WORD_BITS-1:0] load_word;

`ifdef AR_TXD_FIFO_EN
    logic fifo_full, fifo_empty;

    assign load = alive_q & (state_q == IDLE) & ~fifo_empty;
    assign rdy  = alive_q & (~fifo_full | load);

    ar_txd_fifo #(
        .W     (WORD_BITS),
        .DEPTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (st & rdy),
        .din_i   (ar_pack(adr, dat)),
        .pop_i   (load),
        .dout_o  (load_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign rdy       = alive_q & (state_q == IDLE);
    assign load      = st & rdy;
    assign load_word = ar_pack(adr, dat);
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        half_d  = half_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = BIT_HI;
                    word_d  = load_word;
                    bit_d   = '0;
                    half_d  = HW'(HALF - 1);
                end
            end
            BIT_HI: begin
                if (half_q == '0) begin
                    state_d = BIT_LO;
                    half_d  = HW'(HALF - 1);
                end else begin
                    half_d = half_q - 1'b1;
                end
            end
            BIT_LO: begin
                if (half_q != '0) begin
                    half_d = half_q - 1'b1;
                end else if (bit_q == 5'd31) begin
                    state_d = GAP;
                    half_d  = '0;
                    gap_d   = GW'(GAP_CYC - 1);
                end else begin
                    state_d = BIT_HI;
                    bit_d   = bit_q + 1'b1;
                    half_d  = HW'(HALF - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Lines are decoded from the next state so they change with it.
        txd1_d = (state_d == BIT_HI) &  word_d[bit_d];
        txd0_d = (state_d == BIT_HI) & ~word_d[bit_d];
        done_d = (state_d == GAP) & (gap_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            gap_q   <= '0;
            txd1_q  <= 1'b0;
            txd0_q  <= 1'b0;
            done_q  <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            txd1_q  <= txd1_d;
            txd0_q  <= txd0_d;
            done_q  <= done_d;
            alive_q <= 1'b1;
        end
    end

    assign TXD1 = txd1_q;
    assign TXD0 = txd0_q;
    assign done = done_q;

endmodule

// File: tb/tb_ar_txd_word.sv
// Bench for ar_txd_word: cycle model of the line timing plus decoded-word tables.
// Build with AR_TXD_FIFO_EN to exercise the FIFO burst path instead of the cycle model.
module tb_ar_txd_word;

    localparam int C      = 8;
    localparam int G      = 8;
    localparam int HALF   = C / 2;
    localparam int WORD_T = 32 * C;
    localparam int GAP_T  = G * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 1'b0;
    logic [7:0]  adr = '0;
    logic [22:0] dat = '0;
    logic        rdy, TXD1, TXD0, done;

    always #5 clk = ~clk;

    ar_txd_word #(
        .CLK_PER_BIT (C),
        .GAP_BITS    (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .adr   (adr),
        .dat   (dat),
        .st    (st),
        .rdy   (rdy),
        .TXD1  (TXD1),
        .TXD0  (TXD0),
        .done  (done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: time since acceptance says everything about the lines.
    bit          chk_en;
    bit          m_active, m_rdy;
    int          m_t;
    logic [31:0] m_seq;
    logic        e1, e0, ed;

    logic cap[$];
    bit   prev_hi;
    int   done_cnt;

    typedef struct {
        logic [7:0]  a;
        logic [22:0] d;
        logic        p;
    } vec_t;

    function automatic logic [31:0] ref_seq(input logic [7:0] a,
                                            input logic [22:0] d);
        logic [31:0] s;
        int ones;
        ones = $countones(a) + $countones(d);
        for (int k = 0; k < 8; k++) s[k] = a[7-k];
        for (int j = 0; j < 23; j++) s[8+j] = d[j];
        s[31] = (ones % 2 == 0);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit s);
        st = s;
        @(posedge clk);
        if (!rst_n) begin
            m_active = 0;
            m_rdy = 0;
        end else begin
            if (m_rdy && st) begin
                m_active = 1;
                m_t = 0;
                m_seq = ref_seq(adr, dat);
            end else if (m_active) begin
                m_t++;
                if (m_t == WORD_T + GAP_T) m_active = 0;
            end
            m_rdy = !m_active;
        end
        e1 = 0; e0 = 0; ed = 0;
        if (m_active) begin
            if (m_t < WORD_T && (m_t % C) < HALF) begin
                e1 = m_seq[m_t / C];
                e0 = !e1;
            end
            ed = (m_t == WORD_T + GAP_T - 1);
        end
        #1;
        if (chk_en) check("cycle", {rdy, TXD1, TXD0, done}, {m_rdy, e1, e0, ed});
        if ((TXD1 | TXD0) && !prev_hi) cap.push_back(TXD1);
        prev_hi = TXD1 | TXD0;
        if (done) done_cnt++;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!rdy && n < 2000) begin
            step(0);
            n++;
        end
        if (!rdy) check("rdy_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            step(0);
            n++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic check_cap(input string tag, input logic [7:0] a,
                             input logic [22:0] d, input logic p);
        logic [7:0]  ga;
        logic [22:0] gd;
        logic        gp;
        if (cap.size() < 32) begin
            check({tag, "_len"}, cap.size(), 32);
            cap.delete();
            return;
        end
        for (int k = 0; k < 8; k++) ga[7-k] = cap.pop_front();
        for (int j = 0; j < 23; j++) gd[j] = cap.pop_front();
        gp = cap.pop_front();
        check({tag, "_label"}, ga, a);
        check({tag, "_data"}, gd, d);
        check({tag, "_parity"}, gp, p);
    endtask

    task automatic send_word(input logic [7:0] a, input logic [22:0] d);
        int target;
        adr = a;
        dat = d;
        cap.delete();
        wait_rdy();
        target = done_cnt + 1;
        step(1);
        adr = 8'($urandom);
        dat = 23'($urandom);
        wait_done(target);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'hA5, 23'h000001, 1'b0};
        tbl[1] = '{8'h00, 23'h000000, 1'b1};
        tbl[2] = '{8'hFF, 23'h7FFFFF, 1'b0};
        tbl[3] = '{8'h01, 23'h000000, 1'b0};
        tbl[4] = '{8'h00, 23'h000003, 1'b1};
        tbl[5] = '{8'h80, 23'h400000, 1'b1};

`ifdef AR_TXD_FIFO_EN
        chk_en = 0;
`else
        chk_en = 1;
`endif
        m_active = 0; m_rdy = 0; m_t = 0; m_seq = '0;
        prev_hi = 0; done_cnt = 0;

        rst_n = 0;
        repeat (3) step(0);
        check("reset_rdy", rdy, 0);
        check("reset_lines", {TXD1, TXD0, done}, 0);
        rst_n = 1;
        step(0);
        check("rdy_after_release", rdy, 1);

        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].a, tbl[i].d);
            check_cap($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].p);
        end

`ifdef AR_TXD_FIFO_EN
        begin
            int acc[$];
            int target;
            int n;
            cap.delete();
            wait_rdy();
            for (int i = 0; i < 5; i++) begin
                adr = 8'h10 + 8'(i);
                dat = 23'(i * 3 + 1);
                if (rdy) acc.push_back(i);
                step(1);
            end
            st = 0;
            check("fifo_accepts", acc.size() >= 4, 1);
            target = done_cnt + acc.size();
            n = 0;
            while (done_cnt < target && n < 5 * 400) begin
                step(0);
                n++;
            end
            if (done_cnt < target) check("fifo_done_timeout", done_cnt, target);
            foreach (acc[k]) begin
                check_cap($sformatf("fifo%0d", k), 8'h10 + 8'(acc[k]),
                          23'(acc[k] * 3 + 1),
                          ref_seq(8'h10 + 8'(acc[k]), 23'(acc[k] * 3 + 1)) >> 31);
            end
        end
`else
        begin
            int d0;
            wait_rdy();
            adr = 8'h3C;
            dat = 23'h12345;
            d0 = done_cnt;
            for (int i = 0; i < 3 * (WORD_T + GAP_T + 1); i++) step(1);
            st = 0;
            check("held_st_dones", done_cnt - d0, 3);
        end

        begin
            int n = 0;
            wait_rdy();
            adr = 8'h5A;
            dat = 23'h2AAAAA;
            step(1);
            while (m_t < 12 * C + 1 && n < 500) begin
                step(0);
                n++;
            end
            rst_n = 0;
            step(0);
            check("midword_reset_lines", {TXD1, TXD0}, 0);
            check("midword_reset_rdy", rdy, 0);
            rst_n = 1;
            step(0);
            check("midword_release_rdy", rdy, 1);
            send_word(8'hC3, 23'h0F0F0F);
            check_cap("post_reset", 8'hC3, 23'h0F0F0F, 1'b1);
        end

        for (int i = 0; i < 4000; i++) begin
            adr = 8'($urandom);
            dat = 23'($urandom);
            step($urandom_range(0, 3) == 0);
        end
        st = 0;
        cap.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
